register_file_mp: RTL

//  Parametrised multi-port register file for the stage-2 decode/operand-fetch path; successor
//  to the fixed 2-read/1-write 32x32 file. Adds N read ports, registered reads with valid,

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_read_port.sv | 42 ++++
 rtl/register_file_mp.sv | 105 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file:
// FSM state encoding, default geometry and the init-sweep fill value.
package regfile_pkg;

  typedef enum logic {
    RF_INIT,
    RF_READY
  } rf_state_t;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 32;
  localparam int MAX_DATA_W       = 64;

  // Mode 1 seeds each register with its own index; anything else clears it.
  function automatic logic [MAX_DATA_W-1:0] init_value(input int unsigned idx, input int init_mode);
    logic [MAX_DATA_W-1:0] value;
    value = '0;
    if (init_mode == 1) value = MAX_DATA_W'(idx);
    return value;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: hardwired-zero and write-bypass selection in
// front of the output data register.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_accept,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] reg_value,
  input  logic              wr_commit,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] value;

  // reg_value is the array contents before this cycle's write lands.
  always_comb begin
    value = reg_value;
    if (ZERO_REG != 0 && rd_addr == '0) begin
      value = '0;
    end else if (BYPASS != 0 && wr_commit && rd_addr == wr_addr) begin
      value = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_accept) begin
      rd_data <= value;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file for decode/operand fetch: registered
// reads with valid, write bypass, optional zero register and a post-reset init sweep.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int   DATA_W    = DEFAULT_DATA_W,
  parameter int   NUM_REGS  = DEFAULT_NUM_REGS,
  parameter int   NUM_RD    = 2,
  parameter int   ZERO_REG  = 1,
  parameter int   INIT_MODE = 1,
  parameter int   BYPASS    = 1,
  localparam int  ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ack,
  output logic                     busy
);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              ready;
  logic              rd_accept;

  assign ready     = (state_q == RF_READY);
  assign busy      = (state_q == RF_INIT);
  assign wr_ack    = wr_en && ready;
  assign rd_accept = rd_en && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Sweep walks every index once, then the file stays ready until the next reset.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RF_INIT: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == ADDR_W'(NUM_REGS - 1)) state_d = RF_READY;
      end
      RF_READY: begin
        state_d = RF_READY;
      end
      default: begin
        state_d = RF_INIT;
      end
    endcase
  end

  // The array has no reset; its contents are only ever established by the sweep.
  always_ff @(posedge clk) begin
    if (state_q == RF_INIT) begin
      regs[idx_q] <= DATA_W'(init_value(32'(idx_q), INIT_MODE));
    end else if (wr_ack && !(ZERO_REG != 0 && wr_addr == '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
    logic [ADDR_W-1:0] port_addr;
    assign port_addr = rd_addr[p*ADDR_W +: ADDR_W];

    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_read_port (
      .clk       (clk),
      .rst       (rst),
      .rd_accept (rd_accept),
      .rd_addr   (port_addr),
      .reg_value (regs[port_addr]),
      .wr_commit (wr_ack),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_data   (rd_data[p*DATA_W +: DATA_W])
    );
  end

endmodule
